// File: rtl/button_conditioner.sv
// Two-button front end: synchronize, debounce, detect presses and add hold-to-repeat.
// Emits single-cycle step_up / step_down enables in the clock domain. Up wins a collision.
//
// state  | meaning
// IDLE   | button released, or pressed while auto-repeat is disabled
// HOLD   | pressed and stepped once, counting towards the first auto-repeat
// REPEAT | auto-repeating, one step every REPEAT_CYCLES
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int HOLD_CYCLES     = 62500000,
  parameter int REPEAT_CYCLES   = 15625000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic       clock,
  input  logic       res,
  input  logic [1:0] buttons,
  output logic [1:0] btn_level,
  output logic [1:0] btn_press,
  output logic       step_up,
  output logic       step_down
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [DB_W-1:0]  DB_TC     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] HOLD_TC   = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] REPEAT_TC = RPT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] step;

  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= buttons;
      sync_b <= sync_a;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bit
    logic [DB_W-1:0]  db_cnt;
    logic             level_q;
    logic             press_q;
    logic             level_nxt;
    logic             rise;
    state_t           state;
    state_t           state_nxt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic             step_bit;

    always_comb begin
      level_nxt = level_q;
      if ((sync_b[i] != level_q) && (db_cnt == DB_TC))
        level_nxt = sync_b[i];
    end

    // The FSM reacts to the level being accepted on this edge, so the first
    // step lines up with btn_press instead of trailing it by a cycle.
    assign rise = level_nxt & ~level_q;

    always_ff @(posedge clock or posedge res) begin
      if (res) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        level_q <= level_nxt;
        press_q <= rise;
        if ((sync_b[i] == level_q) || (db_cnt == DB_TC))
          db_cnt <= '0;
        else
          db_cnt <= db_cnt + DB_W'(1);
      end
    end

    always_ff @(posedge clock or posedge res) begin
      if (res) begin
        state   <= IDLE;
        rpt_cnt <= '0;
      end else begin
        state   <= state_nxt;
        rpt_cnt <= rpt_cnt_nxt;
      end
    end

    always_comb begin
      state_nxt   = state;
      rpt_cnt_nxt = rpt_cnt;
      step_bit    = 1'b0;
      if (!level_nxt) begin
        state_nxt   = IDLE;
        rpt_cnt_nxt = '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              step_bit    = 1'b1;
              rpt_cnt_nxt = '0;
              state_nxt   = REPEAT_EN ? HOLD : IDLE;
            end
          end
          HOLD: begin
            if (rpt_cnt == HOLD_TC) begin
              step_bit    = 1'b1;
              rpt_cnt_nxt = '0;
              state_nxt   = REPEAT;
            end else begin
              rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
            end
          end
          REPEAT: begin
            if (rpt_cnt == REPEAT_TC) begin
              step_bit    = 1'b1;
              rpt_cnt_nxt = '0;
            end else begin
              rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
            end
          end
          default: begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
          end
        endcase
      end
    end

    assign btn_level[i] = level_q;
    assign btn_press[i] = press_q;
    assign step[i]      = step_bit;
  end

  // A down step colliding with an up step is dropped, not deferred.
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      step_up   <= 1'b0;
      step_down <= 1'b0;
    end else begin
      step_up   <= step[0];
      step_down <= step[1] & ~step[0];
    end
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage that feeds the lab up/down counter.
- Takes the two raw, asynchronous pushbuttons and, for each one, synchronizes, debounces and edge-detects it, then adds hold-to-repeat.
- Produces single-cycle STEP_UP/STEP_DOWN enables in the CLOCK domain. The counter consumes these directly, with no derived clock.
- BUTTONS[0] = up, BUTTONS[1] = down; up has priority, matching the counter.

Parameters:
- DEBOUNCE_CYCLES, 1250000, consecutive stable cycles needed to accept a level change (10 ms at 125 MHz).
- HOLD_CYCLES, 62500000, cycles from accepted press to first auto-repeat step (0.5 s).
- REPEAT_CYCLES, 15625000, cycles between auto-repeat steps (8 Hz).
- REPEAT_EN, 1, set to 0 to disable auto-repeat (one step per press only).

Ports:
- CLOCK  in  1  system clock, 125 MHz.
- RES  in  1  reset, asynchronous, active-high.
- BUTTONS  in  2  raw pushbuttons, asynchronous; [0] up, [1] down.
- BTN_LEVEL  out  2  debounced button levels.
- BTN_PRESS  out  2  one-cycle pulse per accepted press (rising edge of BTN_LEVEL).
- STEP_UP  out  1  one-cycle count-up enable.
- STEP_DOWN  out  1  one-cycle count-down enable.

Behaviour:
- Interface: one clock, CLOCK. RES is asynchronous and active-high.
- Reset values: all outputs 0, synchronizer flops 0, debounce counters 0, repeat FSMs IDLE, repeat counters 0. RES asserted mid-operation clears everything immediately and drops any pulse in progress.
- After RES deasserts, a button already held counts as a new press once the debounce completes.
- Synchronizer:
  - Two flops per bit.
  - Sync value reflects BUTTONS after 2 rising edges.
- Debounce, per bit:
  - Counter increments each edge while sync != BTN_LEVEL.
  - Counter clears to 0 on any edge where sync == BTN_LEVEL.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, BTN_LEVEL takes the sync value and the counter clears.
  - Total pin-to-BTN_LEVEL latency: 2 + DEBOUNCE_CYCLES edges.
  - Glitches shorter than DEBOUNCE_CYCLES produce no change.
  - Counter width: clog2(DEBOUNCE_CYCLES)+1; it never wraps.
- BTN_PRESS[i]: high exactly in the first cycle BTN_LEVEL[i] = 1. Releases produce no pulse.
- Repeat FSM, per bit, with states IDLE, HOLD, REPEAT:
  - IDLE: on BTN_PRESS[i], emit step[i], clear repeat counter, go to HOLD. If REPEAT_EN = 0, stay in IDLE instead.
  - HOLD: each edge, if counter == HOLD_CYCLES-1, emit step[i], clear counter, go to REPEAT; otherwise increment.
  - REPEAT: each edge, if counter == REPEAT_CYCLES-1, emit step[i] and clear counter; otherwise increment.
  - Any state: BTN_LEVEL[i] = 0 returns the FSM to IDLE and clears the counter. No step is emitted in that cycle, even if the counter is at terminal count.
  - Counter width: clog2(max(HOLD_CYCLES, REPEAT_CYCLES))+1.
- Output arbitration (registered, zero extra latency beyond step[i]):
  - STEP_UP = step[0].
  - STEP_DOWN = step[1] & ~step[0].
  - When both steps occur in the same cycle, only STEP_UP pulses; the down step is dropped, not deferred.
  - STEP_UP and STEP_DOWN are never high together.
  - Each step is high for exactly one cycle.
- The two bits are fully independent, apart from the arbitration above.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, with edges numbered from the first edge that samples BUTTONS high.

1. Clean press: BUTTONS=01 held -> BTN_LEVEL[0], BTN_PRESS[0] and STEP_UP rise at edge 6 and BTN_PRESS[0]/STEP_UP last one cycle; further STEP_UP pulses at edges 16, 21, 26.
2. Bounce: BUTTONS[0] toggles every 2 cycles for 40 cycles, then stays 0 -> BTN_LEVEL, BTN_PRESS and STEP_UP stay 0 throughout.
3. Short tap: BUTTONS=01 for 8 cycles, then 00 -> exactly one STEP_UP (edge 6); BTN_LEVEL[0] falls 6 edges after release; no repeat pulses.
4. Simultaneous press: BUTTONS 00->11 held -> at edge 6 STEP_UP=1 and STEP_DOWN=0; at edge 16 STEP_UP=1 and STEP_DOWN=0 again. A separate bench, run with REPEAT_EN=0, drives BUTTONS=10 -> single STEP_DOWN at edge 6.
5. Release at terminal count: BUTTONS=01 held so that BTN_LEVEL[0] falls on the edge where the HOLD counter equals 9 -> no STEP_UP that cycle; FSM returns to IDLE.
6. Async reset mid-hold: assert RES between clock edges while in REPEAT -> all outputs 0 immediately; after release with the button still held, STEP_UP returns 6 edges later.
